// File: rtl/icb_arb_5to1.sv
// Five-initiator ICB ext arbiter onto one shared slave port.
// Grant is locked from command acceptance through the last response beat.
package icb_ext_pkg;
  localparam int ICB_AW    = 32;
  localparam int ICB_DW    = 32;
  localparam int ICB_LEN_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [ICB_AW-1:0]    addr;
    logic                 read;
    logic [ICB_LEN_W-1:0] len;
  } icb_ext_cmd_m_t;

  typedef struct packed {
    logic                w_valid;
    logic [ICB_DW-1:0]   wdata;
    logic [ICB_DW/8-1:0] wmask;
  } icb_ext_wr_m_t;

  typedef struct packed { logic ready;     } icb_ext_cmd_s_t;
  typedef struct packed { logic w_ready;   } icb_ext_wr_s_t;
  typedef struct packed { logic rsp_ready; } icb_ext_rsp_m_t;

  typedef struct packed {
    logic              rsp_valid;
    logic [ICB_DW-1:0] rsp_rdata;
    logic              rsp_err;
  } icb_ext_rsp_s_t;
endpackage

// Per-master return path: handshakes only reach the granted master in the
// matching phase; response payload fans out ungated.
module icb_arb_port
  import icb_ext_pkg::*;
(
  input  logic           sel,
  input  logic           in_cmd,
  input  logic           in_wr,
  input  logic           in_rsp,
  input  icb_ext_cmd_s_t s_cmd_ready,
  input  icb_ext_wr_s_t  s_wr_ready,
  input  icb_ext_rsp_s_t s_rsp,
  output icb_ext_cmd_s_t m_cmd_rsp,
  output icb_ext_wr_s_t  m_wr_rsp,
  output icb_ext_rsp_s_t m_rsp
);
  always_comb begin
    m_cmd_rsp.ready  = sel & in_cmd & s_cmd_ready.ready;
    m_wr_rsp.w_ready = sel & in_wr & s_wr_ready.w_ready;
    m_rsp            = s_rsp;
    m_rsp.rsp_valid  = sel & in_rsp & s_rsp.rsp_valid;
  end
endmodule

module icb_arb_5to1
  import icb_ext_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int LEN_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  icb_ext_cmd_m_t m_cmd       [5],
  input  icb_ext_wr_m_t  m_wr        [5],
  output icb_ext_cmd_s_t m_cmd_rsp   [5],
  output icb_ext_wr_s_t  m_wr_rsp    [5],
  output icb_ext_rsp_s_t m_rsp       [5],
  input  icb_ext_rsp_m_t m_rsp_ready [5],
  output icb_ext_cmd_m_t s_cmd,
  output icb_ext_wr_m_t  s_wr,
  input  icb_ext_cmd_s_t s_cmd_ready,
  input  icb_ext_wr_s_t  s_wr_ready,
  input  icb_ext_rsp_s_t s_rsp,
  output icb_ext_rsp_m_t s_rsp_ready,
  output logic [2:0]     gnt_id,
  output logic           busy
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RSP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic [2:0]       last_gnt_q, last_gnt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [4:0] req;
  logic [2:0] pick, idx;
  logic       pick_vld;
  logic       in_cmd, in_wr, in_rsp;

  assign in_cmd = (state_q == ST_CMD);
  assign in_wr  = (state_q == ST_WDATA);
  assign in_rsp = (state_q == ST_RSP);

  always_comb begin
    for (int i = 0; i < 5; i++) req[i] = m_cmd[i].valid;
  end

  // Both searches run backwards so the first candidate in priority order is
  // the last one written.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    if (ARB_MODE == 1) begin
      for (int i = 4; i >= 0; i--) begin
        if (req[i]) begin
          pick     = 3'(i);
          pick_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 5; k >= 1; k--) begin
        idx = 3'((int'(last_gnt_q) + k) % 5);
        if (req[idx]) begin
          pick     = idx;
          pick_vld = 1'b1;
        end
      end
    end
  end

  // Payloads follow gnt_id in every state; only valid/ready are phase-gated.
  always_comb begin
    s_cmd                 = m_cmd[0];
    s_wr                  = m_wr[0];
    s_rsp_ready.rsp_ready = m_rsp_ready[0].rsp_ready;
    for (int i = 1; i < 5; i++) begin
      if (gnt_id_q == 3'(i)) begin
        s_cmd                 = m_cmd[i];
        s_wr                  = m_wr[i];
        s_rsp_ready.rsp_ready = m_rsp_ready[i].rsp_ready;
      end
    end
    s_cmd.valid           = s_cmd.valid & in_cmd;
    s_wr.w_valid          = s_wr.w_valid & in_wr;
    s_rsp_ready.rsp_ready = s_rsp_ready.rsp_ready & in_rsp;
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_id_d = pick;
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        if (s_cmd.valid && s_cmd_ready.ready) begin
          cnt_d   = s_cmd.len;
          state_d = s_cmd.read ? ST_RSP : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (s_wr.w_valid && s_wr_ready.w_ready) begin
          if (cnt_q == '0) state_d = ST_RSP;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_RSP: begin
        if (s_rsp.rsp_valid && s_rsp_ready.rsp_ready) begin
          if (cnt_q == '0) begin
            state_d    = ST_IDLE;
            last_gnt_d = gnt_id_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= '0;
      last_gnt_q <= 3'd4;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_port
    icb_arb_port u_port (
      .sel         (gnt_id_q == 3'(g)),
      .in_cmd      (in_cmd),
      .in_wr       (in_wr),
      .in_rsp      (in_rsp),
      .s_cmd_ready (s_cmd_ready),
      .s_wr_ready  (s_wr_ready),
      .s_rsp       (s_rsp),
      .m_cmd_rsp   (m_cmd_rsp[g]),
      .m_wr_rsp    (m_wr_rsp[g]),
      .m_rsp       (m_rsp[g])
    );
  end

  assign gnt_id = gnt_id_q;
  assign busy   = (state_q != ST_IDLE);
endmodule
